// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its buffer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          BUF_DEPTH        = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } buf_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO holding fetched {instr, pc} pairs; flush wins over push/pop.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [63:0] push_data_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [63:0] head_o,
  output logic [1:0]  count_o
);

  buf_entry_t mem_q [BUF_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push_i & ((count_q != 2'(BUF_DEPTH)) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory read, 2-entry buffer to decode,
// redirect handling that drains an in-flight request before refetching.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = fetch_pkg::BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [1:0]  dbg_state_o
);
  import fetch_pkg::*;

  localparam logic [1:0] DEPTH_L = 2'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  target_q, target_d;
  logic         req_q, req_d;

  logic         ack;
  logic         pop;
  logic         push;
  logic         flush;
  logic [1:0]   count;
  logic [1:0]   cnt_next;
  logic [31:0]  redirect_tgt;
  logic [63:0]  head_raw;
  buf_entry_t   head;
  buf_entry_t   push_entry;

  assign ack          = req_q & mem_ack;
  assign pop          = out_valid & out_ready;
  assign redirect_tgt = align_word(redirect_pc);
  assign cnt_next     = count + {1'b0, ack} - {1'b0, pop};
  assign push_entry   = '{instr: mem_rdata, pc: fetch_pc_q};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    req_d      = req_q;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        if (redirect) fetch_pc_d = redirect_tgt;
      end
      S_REQ: begin
        if (redirect) begin
          flush = 1'b1;
          // An unanswered request cannot be withdrawn; drain it in DISCARD.
          if (req_q && !mem_ack) begin
            state_d  = S_DISCARD;
            target_d = redirect_tgt;
          end else begin
            fetch_pc_d = redirect_tgt;
            req_d      = 1'b1;
          end
        end else begin
          push = ack;
          if (ack) fetch_pc_d = fetch_pc_q + 32'd4;
          req_d = (req_q & ~ack) | (cnt_next < DEPTH_L);
        end
      end
      S_DISCARD: begin
        req_d = 1'b1;
        if (redirect) target_d = redirect_tgt;
        if (ack) begin
          state_d    = S_REQ;
          fetch_pc_d = redirect ? redirect_tgt : target_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      req_q      <= req_d;
    end
  end

  fetch_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head_raw),
    .count_o     (count)
  );

  assign head        = head_raw;
  assign mem_req     = req_q;
  assign mem_addr    = fetch_pc_q;
  assign out_valid   = (count != 2'd0);
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written redirect/reset
// sequences, then random traffic against a queue-based reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .dbg_state_o (dbg_state)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_pc);
    check({tag, ".mem_req"}, {31'b0, mem_req}, {31'b0, e_req});
    if (e_req) check({tag, ".mem_addr"}, mem_addr, e_addr);
    check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
    if (e_valid) begin
      check({tag, ".out_pc"}, out_pc, e_pc);
      check({tag, ".out_instr"}, out_instr, data_of(e_pc));
    end
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic drive(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
    mem_ack     = ack;
    out_ready   = ready;
    redirect    = redir;
    redirect_pc = rpc;
    mem_rdata   = data_of(mem_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(F, F, F, 32'h0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ack;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[12];

  // Reference model state
  logic        m_started, m_req, m_disc;
  logic [31:0] m_pc, m_tgt;
  logic [63:0] exp_q[$];

  task automatic model_step(input logic ack, input logic rdy, input logic redir,
                            input logic [31:0] rpc, input logic [31:0] rdata);
    logic        ackd;
    logic        popd;
    logic [31:0] tgt;
    ackd = m_req && ack;
    popd = (exp_q.size() != 0) && rdy;
    tgt  = {rpc[31:2], 2'b00};
    if (!m_started) begin
      m_started = 1'b1;
      m_req     = 1'b1;
      if (redir) m_pc = tgt;
    end else if (m_disc) begin
      if (redir) m_tgt = tgt;
      if (ackd) begin
        m_disc = 1'b0;
        m_pc   = m_tgt;
      end
    end else begin
      if (popd) void'(exp_q.pop_front());
      if (redir) begin
        exp_q.delete();
        if (m_req && !ackd) begin
          m_disc = 1'b1;
          m_tgt  = tgt;
        end else begin
          m_pc  = tgt;
          m_req = 1'b1;
        end
      end else begin
        if (ackd) begin
          exp_q.push_back({rdata, m_pc});
          m_pc = m_pc + 32'd4;
        end
        m_req = (m_req && !ackd) || (exp_q.size() < 2);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{T, T, F, 32'h0, F, 32'd0,  F, 32'd0};
    vecs[1]  = '{T, T, F, 32'h0, T, 32'd0,  F, 32'd0};
    vecs[2]  = '{T, T, F, 32'h0, T, 32'd4,  T, 32'd0};
    vecs[3]  = '{T, T, F, 32'h0, T, 32'd8,  T, 32'd4};
    vecs[4]  = '{T, F, F, 32'h0, T, 32'd12, T, 32'd8};
    vecs[5]  = '{T, F, F, 32'h0, F, 32'd16, T, 32'd8};
    vecs[6]  = '{F, T, F, 32'h0, F, 32'd16, T, 32'd8};
    vecs[7]  = '{F, F, F, 32'h0, T, 32'd16, T, 32'd12};
    vecs[8]  = '{T, F, F, 32'h0, T, 32'd16, T, 32'd12};
    vecs[9]  = '{F, T, F, 32'h0, F, 32'd20, T, 32'd12};
    vecs[10] = '{F, T, F, 32'h0, T, 32'd20, T, 32'd16};
    vecs[11] = '{F, F, F, 32'h0, T, 32'd20, F, 32'd0};

    @(negedge clk);
    do_reset();
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.out_instr", out_instr, 32'h0);
    check("reset.out_pc", out_pc, 32'h0);

    // Streaming, back-pressure and resume
    for (int i = 0; i < 12; i++) begin
      check_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc);
      drive(vecs[i].ack, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      tick();
    end

    // Redirect while a slow request is outstanding
    do_reset();
    check_out("dsc.c0", F, 32'h0, F, 32'h0);   drive(T, T, F, 32'h0);   tick();
    check_out("dsc.c1", T, 32'h0, F, 32'h0);   drive(T, T, F, 32'h0);   tick();
    check_out("dsc.c2", T, 32'h4, T, 32'h0);   drive(T, T, F, 32'h0);   tick();
    check_out("dsc.c3", T, 32'h8, T, 32'h4);   drive(F, T, F, 32'h0);   tick();
    check_out("dsc.c4", T, 32'h8, F, 32'h0);   drive(F, T, T, 32'h100); tick();
    check_out("dsc.c5", T, 32'h8, F, 32'h0);   drive(F, T, F, 32'h0);   tick();
    check_out("dsc.c6", T, 32'h8, F, 32'h0);   drive(T, T, F, 32'h0);   tick();
    check_out("dsc.c7", T, 32'h100, F, 32'h0); drive(T, T, F, 32'h0);   tick();
    check_out("dsc.c8", T, 32'h104, T, 32'h100);

    // Redirect coincident with ack, misaligned target
    do_reset();
    drive(T, T, F, 32'h0); tick();
    check_out("coin.c1", T, 32'h0, F, 32'h0);   drive(T, T, T, 32'h203); tick();
    check_out("coin.c2", T, 32'h200, F, 32'h0); drive(T, T, F, 32'h0);   tick();
    check_out("coin.c3", T, 32'h204, T, 32'h200);

    // Address wrap at the top of the space
    do_reset();
    drive(T, T, F, 32'h0); tick();
    drive(T, T, T, 32'hFFFF_FFFC); tick();
    check_out("wrap.c2", T, 32'hFFFF_FFFC, F, 32'h0);   drive(T, T, F, 32'h0); tick();
    check_out("wrap.c3", T, 32'h0, T, 32'hFFFF_FFFC);   drive(T, T, F, 32'h0); tick();
    check_out("wrap.c4", T, 32'h4, T, 32'h0);

    // Asynchronous reset with a request in flight
    drive(F, F, F, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("arst.mem_req", {31'b0, mem_req}, 32'h0);
    check("arst.out_valid", {31'b0, out_valid}, 32'h0);
    check("arst.mem_addr", mem_addr, 32'h0);
    check("arst.out_pc", out_pc, 32'h0);
    check("arst.out_instr", out_instr, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    check_out("arst.c0", F, 32'h0, F, 32'h0);
    check("arst.c0.mem_addr", mem_addr, 32'h0);
    drive(T, T, F, 32'h0); tick();
    check_out("arst.c1", T, 32'h0, F, 32'h0);

    // Random traffic against the reference model
    do_reset();
    m_started = 1'b0;
    m_req     = 1'b0;
    m_disc    = 1'b0;
    m_pc      = 32'h0;
    m_tgt     = 32'h0;
    exp_q.delete();
    for (int c = 0; c < 800; c++) begin
      logic        r_ack, r_rdy, r_redir;
      logic [31:0] r_rpc, r_data;
      check("rnd.mem_req", {31'b0, mem_req}, {31'b0, m_req});
      if (m_req) check("rnd.mem_addr", mem_addr, m_pc);
      check("rnd.out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("rnd.out_pc", out_pc, exp_q[0][31:0]);
        check("rnd.out_instr", out_instr, exp_q[0][63:32]);
      end
      r_ack   = ($urandom_range(0, 99) < 60);
      r_rdy   = ($urandom_range(0, 99) < 65);
      r_redir = ($urandom_range(0, 99) < 7);
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      r_data  = $urandom;
      mem_ack     = r_ack;
      out_ready   = r_rdy;
      redirect    = r_redir;
      redirect_pc = r_rpc;
      mem_rdata   = r_data;
      model_step(r_ack, r_rdy, r_redir, r_rpc, r_data);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
